fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 128 ++++++++++++
 tb/tb_fetch_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end with a single in-flight memory
// request and a DEPTH-entry {instr, pc} buffer feeding decode.
// Optional feature macro: FETCH_BYPASS_EN -- when defined, a response arriving
// with the buffer empty is presented to decode in the same cycle.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_pcplus4
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic          outstanding_q, outstanding_d;
    logic          discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   pc_mem_q    [DEPTH];

    logic [CW:0]   occupancy;
    logic          grant, resp, accept, bypass, push, pop;

    // Request gating, response acceptance and decode-side view of the buffer
    always_comb begin
        // Buffered words plus the one in flight must leave room for the reply
        occupancy = {1'b0, count_q} + {{CW{1'b0}}, outstanding_q};
        imem_req  = !reset && !redirect && (!outstanding_q || imem_rvalid) &&
                    (occupancy < (CW+1)'(DEPTH));
        imem_addr = fetch_pc_q;
        grant     = imem_req && imem_gnt;
        resp      = outstanding_q && imem_rvalid;
        accept    = resp && !discard_q && !redirect && !reset;
`ifdef FETCH_BYPASS_EN
        bypass    = accept && (count_q == '0);
`else
        bypass    = 1'b0;
`endif
        dec_valid   = !reset && !redirect && ((count_q != '0) || bypass);
        dec_instr   = bypass ? imem_rdata : instr_mem_q[rd_ptr_q];
        dec_pc      = bypass ? req_pc_q   : pc_mem_q[rd_ptr_q];
        dec_pcplus4 = dec_pc + 32'd4;
        // A bypassed word is consumed directly and never touches the buffer
        pop  = dec_valid && dec_ready && !bypass;
        push = accept && !(bypass && dec_ready);
    end

    // Next-state for fetch pc, in-flight tracking and buffer pointers
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        if (resp) begin
            outstanding_d = 1'b0;
            discard_d     = 1'b0;
        end
        if (redirect) begin
            fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            // The reply still in flight belongs to the old path
            if (outstanding_q && !imem_rvalid) discard_d = 1'b1;
        end else begin
            if (grant) begin
                outstanding_d = 1'b1;
                req_pc_d      = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + 32'd4;
            end
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; reset overrides every other event
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC & 32'hFFFF_FFFC;
            req_pc_q      <= RESET_PC & 32'hFFFF_FFFC;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // Buffer storage; contents are qualified by count so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]    <= req_pc_q;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench with a behavioural memory responder and an
// in-order expected-program-counter model. Honors FETCH_BYPASS_EN if defined.
module tb_fetch_unit;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, imem_req, imem_gnt, imem_rvalid, redirect, dec_valid, dec_ready;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, dec_instr, dec_pc, dec_pcplus4;

    int total = 0;
    int bad   = 0;

    // Memory responder state
    logic        mem_pend;
    int          mem_cnt;
    logic [31:0] mem_addr;
    int          dly_max;
    // Expected-stream model
    logic [31:0] exp_fetch, exp_dec;
    logic        prev_wait, prev_rst, prev_redir, seen_wrap;
    logic [31:0] prev_addr;
    int          hs_cnt;
    // Snapshots of the last sampled outputs
    logic        s_req, s_dv;
    logic [31:0] s_addr;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
        .dec_pc(dec_pc), .dec_pcplus4(dec_pcplus4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs after the falling edge, sample just after, update model
    task automatic cyc(input logic rst_v, input logic gnt_v, input logic rdy_v,
                       input logic rd_v, input logic [31:0] rpc_v);
        logic rv;
        @(negedge clk);
        rv = mem_pend ? (mem_cnt == 0) : ($urandom_range(9) == 0);
        reset       = rst_v;
        imem_gnt    = gnt_v;
        imem_rvalid = rv;
        imem_rdata  = (rv && mem_pend) ? memw(mem_addr) : $urandom;
        redirect    = rd_v;
        redirect_pc = rpc_v;
        dec_ready   = rdy_v;
        #1;
        s_req = imem_req; s_dv = dec_valid; s_addr = imem_addr;
        if (rst_v) begin
            chk("reset_req", {31'd0, imem_req}, 32'd0);
            chk("reset_dvalid", {31'd0, dec_valid}, 32'd0);
            exp_fetch = RESET_PC; exp_dec = RESET_PC;
            mem_pend = 1'b0; prev_wait = 1'b0; prev_redir = 1'b0; prev_rst = 1'b1;
        end else begin
            if (imem_req) chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
            if (rd_v) begin
                chk("redir_req", {31'd0, imem_req}, 32'd0);
                chk("redir_dvalid", {31'd0, dec_valid}, 32'd0);
            end
            if (prev_redir) chk("post_redir_dvalid", {31'd0, dec_valid}, 32'd0);
            if (prev_wait && !rd_v) begin
                chk("hold_req", {31'd0, imem_req}, 32'd1);
                chk("hold_addr", imem_addr, prev_addr);
            end
            if (prev_rst && !rd_v) begin
                chk("first_req", {31'd0, imem_req}, 32'd1);
                chk("first_addr", imem_addr, RESET_PC);
            end
            if (mem_pend && !rv) chk("one_in_flight", {31'd0, imem_req}, 32'd0);
            if (dec_valid && rdy_v) begin
                chk("dec_pc", dec_pc, exp_dec);
                chk("dec_instr", dec_instr, memw(exp_dec));
                chk("dec_pcplus4", dec_pcplus4, exp_dec + 32'd4);
                if (dec_pc == 32'hFFFF_FFFC && dec_pcplus4 == 32'h0) seen_wrap = 1'b1;
                exp_dec = exp_dec + 32'd4;
                hs_cnt++;
            end
            if (rv) mem_pend = 1'b0;
            else if (mem_pend) mem_cnt--;
            if (imem_req && gnt_v) begin
                chk("req_addr", imem_addr, exp_fetch);
                exp_fetch = exp_fetch + 32'd4;
                mem_pend  = 1'b1;
                mem_addr  = imem_addr;
                mem_cnt   = $urandom_range(dly_max - 1);
            end
            if (rd_v) begin
                exp_fetch = rpc_v & 32'hFFFF_FFFC;
                exp_dec   = rpc_v & 32'hFFFF_FFFC;
            end
            prev_rst   = 1'b0;
            prev_redir = rd_v;
            prev_wait  = imem_req && !gnt_v;
            prev_addr  = imem_addr;
        end
    endtask

    initial begin
        logic [31:0] a3;
        int start;
        reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
        mem_pend = 1'b0; mem_cnt = 0; mem_addr = '0; dly_max = 1;
        exp_fetch = RESET_PC; exp_dec = RESET_PC;
        prev_wait = 1'b0; prev_rst = 1'b0; prev_redir = 1'b0; prev_addr = '0;
        seen_wrap = 1'b0; hs_cnt = 0;

        // Reset, including a redirect and grant that reset must override
        cyc(1, 1, 1, 1, 32'h0000_0040);
        cyc(1, 0, 0, 0, 0);
        // Sequential fetch with single-cycle memory latency
        for (int i = 0; i < 12; i++) cyc(0, 1, 1, 0, 0);
        // Decode stall fills the buffer and throttles requests
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, 0);
        chk("stall_req", {31'd0, s_req}, 32'd0);
        chk("stall_dvalid", {31'd0, s_dv}, 32'd1);
        for (int i = 0; i < 10; i++) cyc(0, 1, 1, 0, 0);
        // Grant withheld: request and address hold
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1, 0, 0);
            if (i == 2) a3 = s_addr;
        end
        chk("gnt_low_req", {31'd0, s_req}, 32'd1);
        chk("gnt_low_addr", s_addr, a3);
        // Redirect while a slow response is in flight
        dly_max = 3;
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 1, 32'h0000_0103);
        for (int i = 0; i < 12; i++) cyc(0, 1, 1, 0, 0);
        dly_max = 1;
        // Address wrap at the top of memory
        cyc(0, 1, 1, 1, 32'hFFFF_FFF4);
        for (int i = 0; i < 14; i++) cyc(0, 1, 1, 0, 0);
        chk("wrap_seen", {31'd0, seen_wrap}, 32'd1);
        // Response-to-decode latency from an empty buffer
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("rvalid_cycle_dvalid", {31'd0, s_dv}, {31'd0, BYP});
        cyc(0, 0, 0, 0, 0);
        chk("next_cycle_dvalid", {31'd0, s_dv}, 32'd1);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            dly_max = 1 + $urandom_range(3);
            rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(31))) : $urandom;
            cyc($urandom_range(199) == 0, $urandom_range(9) < 7, $urandom_range(9) < 6,
                $urandom_range(19) == 0, rpc);
        end
        // Drain: forward progress under a bounded cycle budget
        dly_max = 2;
        start = hs_cnt;
        for (int i = 0; i < 200 && (hs_cnt - start) < 20; i++) cyc(0, 1, 1, 0, 0);
        chk("drain_progress", 32'(hs_cnt - start), 32'd20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
